// File: rtl/sm_pkg.sv
// sm_input_filter shared package: width helper,
// parameter legality and per-channel output bundle.
package sm_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int stable);
    return (clog2(stable) < 1) ? 1 : clog2(stable);
  endfunction

  function automatic bit params_ok(
    input int sync,
    input int stable
  );
    return (sync >= 1) && (stable >= 1);
  endfunction

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
  } ch_out_t;

endpackage

// File: rtl/sm_input_filter_if.sv
// sm_input_filter pin bundle; toggle exists only
// when SM_INPUT_FILTER_TOGGLE_EN is defined.
interface sm_input_filter_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] d;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                changed;
`ifdef SM_INPUT_FILTER_TOGGLE_EN
  logic [CHANNELS-1:0] toggle;
`endif

  modport master (
    output d,
    input  q, rise, fall, changed
`ifdef SM_INPUT_FILTER_TOGGLE_EN
    , input toggle
`endif
  );

  modport slave (
    input  d,
    output q, rise, fall, changed
`ifdef SM_INPUT_FILTER_TOGGLE_EN
    , output toggle
`endif
  );
endinterface

// File: rtl/sm_input_filter_ch.sv
// One channel: synchroniser, stability counter,
// filtered level and rise/fall pulses.
module sm_input_filter_ch
  import sm_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    d,
  output ch_out_t o,
  output logic    fire
);
  localparam int CNT_W = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] s;
  logic                   sd;
  logic [CNT_W-1:0]       cnt;

  assign sd   = s[SYNC_STAGES-1];
  // Next edge commits a change; lets the top
  // register changed alongside rise/fall.
  assign fire = (sd != o.q) && (cnt == LAST);

  // Shift raw input through the synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      s[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  // Accept sd only after it held for the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o.q    <= RESET_VAL;
      o.rise <= 1'b0;
      o.fall <= 1'b0;
      cnt    <= '0;
    end else begin
      o.rise <= 1'b0;
      o.fall <= 1'b0;
      if (sd == o.q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        o.q    <= sd;
        o.rise <= sd;
        o.fall <= ~sd;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sm_input_filter.sv
// Multi-channel input synchroniser/debouncer.
// Define SM_INPUT_FILTER_TOGGLE_EN for toggle.
module sm_input_filter
  import sm_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  sm_input_filter_if.slave bus
);
  if (!params_ok(SYNC_STAGES, STABLE_CYCLES))
  begin : g_bad_params
    $fatal(1, "SYNC_STAGES/STABLE_CYCLES < 1");
  end

  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] q_v;
  logic [CHANNELS-1:0] rise_v;
  logic [CHANNELS-1:0] fall_v;
  logic                changed_r;
  ch_out_t             o [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++)
  begin : g_ch
    sm_input_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.d[i]),
      .o    (o[i]),
      .fire (fire[i])
    );
    assign q_v[i]    = o[i].q;
    assign rise_v[i] = o[i].rise;
    assign fall_v[i] = o[i].fall;
  end

  assign bus.q       = q_v;
  assign bus.rise    = rise_v;
  assign bus.fall    = fall_v;
  assign bus.changed = changed_r;

  // changed lands on the same edge as the pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) changed_r <= 1'b0;
    else        changed_r <= |fire;
  end

`ifdef SM_INPUT_FILTER_TOGGLE_EN
  logic [CHANNELS-1:0] toggle_r;
  assign bus.toggle = toggle_r;

  // Flip each latch the cycle after its rise.
  always_ff @(posedge clk) begin
    if (!rst_n) toggle_r <= '0;
    else        toggle_r <= toggle_r ^ rise_v;
  end
`endif
endmodule

// File: tb/tb_sm_input_filter.sv
// Scoreboard bench for sm_input_filter with a
// sliding-window reference model.
module tb_sm_input_filter;
  localparam int CH = 8;
  localparam int SYNC = 2;
  localparam int STABLE = 4;
  localparam logic [CH-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_input_filter_if #(.CHANNELS(CH)) bus ();

  sm_input_filter #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .RESET_VAL    (RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [CH-1:0] q;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] tog;
    logic          ch;
  } exp_t;

  exp_t sbq [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(
    input string         n,
    input logic [CH-1:0] a,
    input logic [CH-1:0] e
  );
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h",
               n, cyc, a, e);
    end
  endtask

  // Reference: sd is d delayed SYNC edges; a bit
  // flips when the last STABLE sd samples all
  // differ from the current q.
  initial begin
    logic [CH-1:0] syncq [$];
    logic [CH-1:0] win [$];
    logic [CH-1:0] sdu;
    logic [CH-1:0] flip;
    exp_t m;
    bit   all;
    m = '{default: '0};
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        syncq.delete();
        for (int k = 0; k < SYNC; k++)
          syncq.push_back(RV);
        win.delete();
        m.q = RV;
        m.rise = '0;
        m.fall = '0;
        m.tog = '0;
        m.ch = 1'b0;
      end else begin
        sdu = syncq.pop_front();
        syncq.push_back(bus.d);
        win.push_back(sdu);
        if (win.size() > STABLE)
          void'(win.pop_front());
        flip = '0;
        if (win.size() == STABLE) begin
          for (int i = 0; i < CH; i++) begin
            all = 1'b1;
            foreach (win[j])
              if (win[j][i] == m.q[i]) all = 1'b0;
            flip[i] = all;
          end
        end
        m.tog = m.tog ^ m.rise;
        m.rise = flip & ~m.q;
        m.fall = flip & m.q;
        m.q = m.q ^ flip;
        m.ch = |flip;
      end
      sbq.push_back(m);
    end
  end

  // Monitor: compare DUT outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("q", bus.q, e.q);
        chk("rise", bus.rise, e.rise);
        chk("fall", bus.fall, e.fall);
        chk("changed", {7'd0, bus.changed},
            {7'd0, e.ch});
`ifdef SM_INPUT_FILTER_TOGGLE_EN
        chk("toggle", bus.toggle, e.tog);
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.d = '0;
    rst_n = 1'b0;
    step(4);
    rst_n = 1'b1;
    step(10);
    // clean step on d[0]
    bus.d = 8'h01;
    step(10);
    // 3-cycle glitch on d[1]
    bus.d = 8'h03;
    step(3);
    bus.d = 8'h01;
    step(10);
    // 4-cycle pulse on d[1]
    bus.d = 8'h03;
    step(4);
    bus.d = 8'h01;
    step(12);
    // simultaneous rise
    bus.d = 8'h00;
    step(10);
    bus.d = 8'h0F;
    step(10);
    // reset mid-count on d[2]
    bus.d = 8'h00;
    step(10);
    bus.d = 8'h04;
    step(3);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);
    // three presses on d[0]
    bus.d = 8'h00;
    step(10);
    for (int p = 0; p < 3; p++) begin
      bus.d = 8'h01;
      step(8);
      bus.d = 8'h00;
      step(8);
    end
    // random traffic with glitches and resets
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(0, 1) == 0)
        bus.d = CH'($urandom);
      else
        bus.d = bus.d ^ (CH'(1) << $urandom_range(0, CH-1));
      step($urandom_range(1, 7));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end
    step(12);
    if (checks < 12) begin
      failures++;
      $display("FAIL too_few_checks got=%0d exp>=12",
               checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/sm_input_filter.md
Name: sm_input_filter

Overview:
- Parametrised successor to the fixed-width two-flop input debouncer used on board switches and buttons.
- Synchronises CHANNELS asynchronous inputs, then accepts a change only after it has been stable for STABLE_CYCLES clocks.
- Emits a clean level plus one-cycle rise/fall pulses per channel, replacing separate debouncer and edge_detector instances in the top level.
- Sits directly behind the board pins, feeding the clock divider controls, debug register address and uart_on.

Parameters:
- CHANNELS, 8: number of independent input bits.
- SYNC_STAGES, 2: synchroniser depth; legal range ≥1.
- STABLE_CYCLES, 4: consecutive cycles a new synced value must hold before q changes; legal range ≥1.
- RESET_VAL, {CHANNELS{1'b0}}: reset value of the synchroniser flops and q, per bit.

Ports:
- clk  in  1  system clock; all flops posedge.
- rst_n  in  1  synchronous, active-low reset.
- d  in  CHANNELS  raw asynchronous inputs.
- q  out  CHANNELS  filtered level.
- rise  out  CHANNELS  one-cycle pulse on q 0->1.
- fall  out  CHANNELS  one-cycle pulse on q 1->0.
- changed  out  1  OR of rise|fall, registered with them.

Behaviour:
- Reset:
  - Sampled on clk edge while rst_n=0.
  - Sync flops and q <= RESET_VAL; counters <= 0; rise, fall, changed <= 0.
  - Reset mid-count discards the pending change; no pulse is emitted.
- Synchroniser: s[0] <= d; s[i] <= s[i-1]. The filter compares sd = s[SYNC_STAGES-1] against q.
- Per-channel counter:
  - Width CNT_W = clog2(STABLE_CYCLES), minimum 1.
  - If sd == q: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: q <= sd; cnt <= 0; rise <= sd, fall <= ~sd.
  - Else: cnt <= cnt+1.
- Pulses: rise/fall default to 0 each cycle. They are high for exactly one cycle, in the same cycle the new q first appears.
- Latency: d changes and is sampled at edge k. q and the pulse appear after edge k+SYNC_STAGES+STABLE_CYCLES-1. With the defaults, that is edge k+5.
- Glitch rejection: if sd returns to q before the count completes, cnt clears. No pulse is emitted and q is unchanged.
- STABLE_CYCLES=1: q follows sd one cycle later. There is no filtering, only synchronisation and edge pulses.
- Channel independence: channels are fully independent. Several channels may pulse in the same cycle; changed is then a single 1.
- Counter range: the counter never exceeds STABLE_CYCLES-1. No wrap-around is possible.
- Data path: no combinational path from d to any output. All outputs are registered.

Optional Feature:
- Macro: SM_INPUT_FILTER_TOGGLE_EN.
- Defined:
  - Adds port toggle, out, CHANNELS wide, reset to 0.
  - toggle[i] inverts in the cycle after rise[i] is high.
  - Gives push-button on/off latches, e.g. for uart_on or clkEnable, without external logic.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package sm_pkg:
  - clog2 constant function.
  - Parameter range checks; SYNC_STAGES<1 or STABLE_CYCLES<1 is a fatal elaboration error.
- Sub-module sm_input_filter_ch:
  - Contains one channel's synchroniser, counter, q, rise and fall.
  - Takes SYNC_STAGES, STABLE_CYCLES and a 1-bit RESET_VAL.
  - The top instantiates it CHANNELS times in a generate loop.
  - The top ORs the pulses into changed, registered.

Test Plan:
- Reset and release, CHANNELS=8, RESET_VAL=8'hA5, d=8'h00:
  - q=8'hA5 while rst_n=0, pulses 0.
  - After release, q becomes 8'h00 at edge 6 after release.
  - fall=8'hA5 for one cycle at that edge; changed=1.
- Clean step, defaults, d[0] 0->1 sampled at edge 10:
  - q[0]=1 and rise[0]=1 after edge 15 only.
  - rise[0]=0 after edge 16.
  - fall and all other bits stay 0.
- Glitch: d[1] high for 3 cycles then low, STABLE_CYCLES=4:
  - q[1], rise[1] and fall[1] never assert.
  - Repeat with a 4-cycle pulse: q[1] goes high at +5, then low 4 cycles later.
  - rise[1] and fall[1] each pulse once.
- Simultaneous: d 8'h00->8'h0F on one edge:
  - rise=8'h0F for a single cycle; changed=1 for one cycle.
- Reset mid-count: d[2] rises; rst_n=0 on the 3rd cycle of the count:
  - q[2]=RESET_VAL[2] and no pulse.
  - After release with d[2] still high, a full 5-cycle latency is observed before rise[2].
- SM_INPUT_FILTER_TOGGLE_EN, three clean presses on d[0]:
  - toggle[0] sequence 0->1->0->1, each change exactly one cycle after rise[0].
  - Toggle bits of channels that receive no presses remain 0.
